io_bus_tx: RTL and testbench

- Host-side transmitter for the shared 48-bit operand bus: the block that feeds packed A (feature) and B (kernel) words to the accelerator over its a_valid/a_ready and b_valid/b_ready handshakes.
- Buffers each stream in its own small FIFO.
- Time-multiplexes both streams onto the single bus, driving at most one valid per cycle.
- Sits between the host/stimulus source and the chip's io_bus pins, and carries NB_LANES=3 packed 16-bit lanes per word.

---
 rtl/io_bus_tx.sv | 205 ++++++++++++++++++++
 tb/tb_io_bus_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_tx.sv
// rtl/io_bus_tx.sv - host-side A/B operand transmitter onto the shared io_bus
//
// Purpose:
//   Buffers host A (feature) and B (kernel) words in one small FIFO per
//   stream. Time-multiplexes the FIFO heads onto the single io_bus. At most
//   one of a_valid / b_valid is driven in any cycle.
//
// Ports:
//   clk, rst_in               clock and synchronous active-high reset
//   a_word/_valid/_ready      host A word push interface
//   b_word/_valid/_ready      host B word push interface
//   io_bus_out, io_bus_oe     bus value and output enable
//   a_valid/a_ready           chip-side A handshake
//   b_valid/b_ready           chip-side B handshake
//   a_sent, b_sent            completed transfer counters (wrapping)
//   idle                      both FIFOs empty and nothing on the bus

module io_bus_tx #(
    parameter int BUS_WIDTH  = 48,
    parameter int LANE_WIDTH = 16,
    parameter int NB_LANES   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic [BUS_WIDTH-1:0] a_word,
    input  logic                 a_word_valid,
    output logic                 a_word_ready,
    input  logic [BUS_WIDTH-1:0] b_word,
    input  logic                 b_word_valid,
    output logic                 b_word_ready,
    output logic [BUS_WIDTH-1:0] io_bus_out,
    output logic                 io_bus_oe,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [CNT_WIDTH-1:0] a_sent,
    output logic [CNT_WIDTH-1:0] b_sent,
    output logic                 idle
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_t;

    sel_t sel;
    logic last_b;   // 1 when B was the most recently served stream

    logic [BUS_WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic [PW-1:0]        wr_a, rd_a, wr_b, rd_b;
    logic [CW-1:0]        cnt_a, cnt_b;

    logic [CNT_WIDTH-1:0] a_sent_q, b_sent_q;

    logic push_a, push_b, hs_a, hs_b;
    logic [CW-1:0] occ_a, occ_b;
    logic na, nb, qa, qb, prefer_a;
    sel_t pick;
    logic [BUS_WIDTH-1:0] head;

    // Host-side ready comes from the registered count only, so a pop in the
    // same cycle never lets a full FIFO accept a word.
    assign a_word_ready = !rst_in && (cnt_a < DEPTH_C);
    assign b_word_ready = !rst_in && (cnt_b < DEPTH_C);

    assign push_a = a_word_valid && a_word_ready;
    assign push_b = b_word_valid && b_word_ready;
    assign hs_a   = !rst_in && (sel == SEL_A) && a_ready;
    assign hs_b   = !rst_in && (sel == SEL_B) && b_ready;

    // Selection looks at words already stored minus this cycle's pop; a word
    // pushed this cycle becomes selectable one edge later.
    assign occ_a = cnt_a - {{(CW-1){1'b0}}, hs_a};
    assign occ_b = cnt_b - {{(CW-1){1'b0}}, hs_b};
    assign na    = (occ_a != '0);
    assign nb    = (occ_b != '0);
    assign qa    = na && a_ready;
    assign qb    = nb && b_ready;

    // Round-robin preference accounts for a handshake completing this edge.
    assign prefer_a = hs_a ? 1'b0 : (hs_b ? 1'b1 : last_b);

    always_comb begin
        pick = SEL_NONE;
        if (qa && qb) begin
            pick = prefer_a ? SEL_A : SEL_B;
        end else if (qa) begin
            pick = SEL_A;
        end else if (qb) begin
            pick = SEL_B;
        end else if (na && nb) begin
            pick = prefer_a ? SEL_A : SEL_B;
        end else if (na) begin
            pick = SEL_A;
        end else if (nb) begin
            pick = SEL_B;
        end
    end

    // FIFO storage: data is not reset, only the pointers and counts are.
    always_ff @(posedge clk) begin
        if (push_a) begin
            mem_a[wr_a] <= a_word;
        end
        if (push_b) begin
            mem_b[wr_b] <= b_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) begin
                wr_a <= wr_a + PW'(1);
            end
            if (hs_a) begin
                rd_a <= rd_a + PW'(1);
            end
            if (push_a && !hs_a) begin
                cnt_a <= cnt_a + CW'(1);
            end else if (!push_a && hs_a) begin
                cnt_a <= cnt_a - CW'(1);
            end

            if (push_b) begin
                wr_b <= wr_b + PW'(1);
            end
            if (hs_b) begin
                rd_b <= rd_b + PW'(1);
            end
            if (push_b && !hs_b) begin
                cnt_b <= cnt_b + CW'(1);
            end else if (!push_b && hs_b) begin
                cnt_b <= cnt_b - CW'(1);
            end
        end
    end

    // Selection FSM and transfer counters.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            sel      <= SEL_NONE;
            last_b   <= 1'b1;
            a_sent_q <= '0;
            b_sent_q <= '0;
        end else begin
            if (hs_a) begin
                a_sent_q <= a_sent_q + CNT_WIDTH'(1);
                last_b   <= 1'b0;
            end else if (hs_b) begin
                b_sent_q <= b_sent_q + CNT_WIDTH'(1);
                last_b   <= 1'b1;
            end

            // A stalled stream yields to the other when only the other can
            // move; otherwise the current word is held on the bus.
            if (sel == SEL_A && !hs_a) begin
                sel <= (nb && b_ready) ? SEL_B : SEL_A;
            end else if (sel == SEL_B && !hs_b) begin
                sel <= (na && a_ready) ? SEL_A : SEL_B;
            end else begin
                sel <= pick;
            end
        end
    end

    always_comb begin
        head = '0;
        if (!rst_in) begin
            if (sel == SEL_A) begin
                head = mem_a[rd_a];
            end else if (sel == SEL_B) begin
                head = mem_b[rd_b];
            end
        end
    end

    // Drive the bus lane by lane; lane i occupies bits [16i+15:16i].
    for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
        assign io_bus_out[i*LANE_WIDTH +: LANE_WIDTH] = head[i*LANE_WIDTH +: LANE_WIDTH];
    end

    assign a_valid   = !rst_in && (sel == SEL_A);
    assign b_valid   = !rst_in && (sel == SEL_B);
    assign io_bus_oe = !rst_in && (sel != SEL_NONE);
    assign a_sent    = rst_in ? '0 : a_sent_q;
    assign b_sent    = rst_in ? '0 : b_sent_q;
    assign idle      = !rst_in && (cnt_a == '0) && (cnt_b == '0) && (sel == SEL_NONE);

endmodule

// File: tb/tb_io_bus_tx.sv
// tb/tb_io_bus_tx.sv - self-checking bench for io_bus_tx

module tb_io_bus_tx;

    logic        clk;
    logic        rst_in;
    logic [47:0] a_word;
    logic        a_word_valid;
    logic        a_word_ready;
    logic [47:0] b_word;
    logic        b_word_valid;
    logic        b_word_ready;
    logic [47:0] io_bus_out;
    logic        io_bus_oe;
    logic        a_valid;
    logic        a_ready;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] a_sent;
    logic [31:0] b_sent;
    logic        idle;

    int n_checks;
    int n_errors;

    io_bus_tx dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .a_word       (a_word),
        .a_word_valid (a_word_valid),
        .a_word_ready (a_word_ready),
        .b_word       (b_word),
        .b_word_valid (b_word_valid),
        .b_word_ready (b_word_ready),
        .io_bus_out   (io_bus_out),
        .io_bus_oe    (io_bus_oe),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .a_sent       (a_sent),
        .b_sent       (b_sent),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [47:0] aw;
        logic        av;
        logic [47:0] bw;
        logic        bv;
        logic        ar;
        logic        br;
        logic        e_awr;
        logic        e_bwr;
        logic        e_av;
        logic        e_bv;
        logic [47:0] e_bus;
        logic        e_idle;
        logic [31:0] e_as;
        logic [31:0] e_bs;
    } vec_t;

    vec_t vecs[$];

    localparam logic [47:0] W  = 48'h0003_0002_0001;
    localparam logic [47:0] B0 = 48'h00B0_00B0_00B0;
    localparam logic [47:0] B1 = 48'h00B1_00B1_00B1;
    localparam logic [47:0] B2 = 48'h00B2_00B2_00B2;
    localparam logic [47:0] B3 = 48'h00B3_00B3_00B3;
    localparam logic [47:0] B4 = 48'h00B4_00B4_00B4;

    function automatic vec_t mk(logic rst, logic [47:0] aw, logic av, logic [47:0] bw,
                                logic bv, logic ar, logic br, logic e_awr, logic e_bwr,
                                logic e_av, logic e_bv, logic [47:0] e_bus, logic e_idle,
                                logic [31:0] e_as, logic [31:0] e_bs);
        vec_t v;
        v.rst = rst; v.aw = aw; v.av = av; v.bw = bw; v.bv = bv; v.ar = ar; v.br = br;
        v.e_awr = e_awr; v.e_bwr = e_bwr; v.e_av = e_av; v.e_bv = e_bv;
        v.e_bus = e_bus; v.e_idle = e_idle; v.e_as = e_as; v.e_bs = e_bs;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [47:0] seq_word [6];
    logic        seq_is_a [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_in = 1'b1;
        a_word = '0; a_word_valid = 1'b0; a_ready = 1'b0;
        b_word = '0; b_word_valid = 1'b0; b_ready = 1'b0;

        //              rst aw av  bw  bv ar br | awr bwr av bv bus idle as bs
        // reset held two cycles, then released
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0, 0,  1, 0, 0));
        // single A word
        vecs.push_back(mk(0, W, 1, 0,  0, 1, 0,   1, 1, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0,   1, 1, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0,   1, 1, 1, 0, W,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0, 0,  1, 1, 0));
        // fill B with b_ready low, then drain back-to-back
        vecs.push_back(mk(0, 0, 0, B0, 1, 0, 0,   1, 1, 0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(0, 0, 0, B1, 1, 0, 0,   1, 1, 0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, B2, 1, 0, 0,   1, 1, 0, 1, B0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, B3, 1, 0, 0,   1, 1, 0, 1, B0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, B4, 1, 0, 0,   1, 0, 0, 1, B0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, B4, 1, 0, 0,   1, 0, 0, 1, B0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, B4, 1, 0, 1,   1, 0, 0, 1, B0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, B4, 1, 0, 1,   1, 1, 0, 1, B1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1,   1, 1, 0, 1, B2, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1,   1, 1, 0, 1, B3, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1,   1, 1, 0, 1, B4, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0, 0,  1, 1, 5));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_in = vecs[i].rst;
            a_word = vecs[i].aw; a_word_valid = vecs[i].av; a_ready = vecs[i].ar;
            b_word = vecs[i].bw; b_word_valid = vecs[i].bv; b_ready = vecs[i].br;
            #1;
            check($sformatf("v%0d_a_word_ready", i), 64'(a_word_ready), 64'(vecs[i].e_awr));
            check($sformatf("v%0d_b_word_ready", i), 64'(b_word_ready), 64'(vecs[i].e_bwr));
            check($sformatf("v%0d_a_valid", i), 64'(a_valid), 64'(vecs[i].e_av));
            check($sformatf("v%0d_b_valid", i), 64'(b_valid), 64'(vecs[i].e_bv));
            check($sformatf("v%0d_io_bus_oe", i), 64'(io_bus_oe), 64'(vecs[i].e_av | vecs[i].e_bv));
            check($sformatf("v%0d_io_bus_out", i), 64'(io_bus_out), 64'(vecs[i].e_bus));
            check($sformatf("v%0d_idle", i), 64'(idle), 64'(vecs[i].e_idle));
            check($sformatf("v%0d_a_sent", i), 64'(a_sent), 64'(vecs[i].e_as));
            check($sformatf("v%0d_b_sent", i), 64'(b_sent), 64'(vecs[i].e_bs));
        end

        // Interleave: queue 3 A and 3 B with readies low, then open both.
        seq_word[0] = 48'h0A00_0A00_0A00; seq_is_a[0] = 1'b1;
        seq_word[1] = 48'h0B00_0B00_0B00; seq_is_a[1] = 1'b0;
        seq_word[2] = 48'h0A01_0A01_0A01; seq_is_a[2] = 1'b1;
        seq_word[3] = 48'h0B01_0B01_0B01; seq_is_a[3] = 1'b0;
        seq_word[4] = 48'h0A02_0A02_0A02; seq_is_a[4] = 1'b1;
        seq_word[5] = 48'h0B02_0B02_0B02; seq_is_a[5] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_ready = 1'b0; b_ready = 1'b0;
            a_word = seq_word[2*k];   a_word_valid = 1'b1;
            b_word = seq_word[2*k+1]; b_word_valid = 1'b1;
        end
        @(negedge clk);
        a_word_valid = 1'b0; b_word_valid = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("ilv%0d_a_valid", k), 64'(a_valid), 64'(seq_is_a[k]));
            check($sformatf("ilv%0d_b_valid", k), 64'(b_valid), 64'(!seq_is_a[k]));
            check($sformatf("ilv%0d_bus", k), 64'(io_bus_out), 64'(seq_word[k]));
            @(negedge clk);
        end
        #1;
        check("ilv_idle", 64'(idle), 64'(1));
        check("ilv_a_sent", 64'(a_sent), 64'(4));
        check("ilv_b_sent", 64'(b_sent), 64'(8));

        // Yield: A stalled while B can move.
        @(negedge clk);
        a_ready = 1'b0; b_ready = 1'b0;
        a_word = 48'h0000_0000_AAAA; a_word_valid = 1'b1;
        @(negedge clk);
        a_word_valid = 1'b0;
        b_word = 48'h0000_0000_BBBB; b_word_valid = 1'b1;
        @(negedge clk);
        b_word_valid = 1'b0;
        #1;
        check("yld_a_valid_pre", 64'(a_valid), 64'(1));
        check("yld_bus_pre", 64'(io_bus_out), 64'(48'h0000_0000_AAAA));
        b_ready = 1'b1;
        @(negedge clk);
        #1;
        check("yld_a_valid", 64'(a_valid), 64'(0));
        check("yld_b_valid", 64'(b_valid), 64'(1));
        check("yld_bus_b", 64'(io_bus_out), 64'(48'h0000_0000_BBBB));
        @(negedge clk);
        #1;
        check("yld_back_a_valid", 64'(a_valid), 64'(1));
        check("yld_back_b_valid", 64'(b_valid), 64'(0));
        check("yld_bus_a", 64'(io_bus_out), 64'(48'h0000_0000_AAAA));
        a_ready = 1'b1; b_ready = 1'b0;
        @(negedge clk);
        #1;
        check("yld_idle", 64'(idle), 64'(1));
        check("yld_a_sent", 64'(a_sent), 64'(5));
        check("yld_b_sent", 64'(b_sent), 64'(9));

        // Reset mid-stream with two A words buffered and a_valid high.
        @(negedge clk);
        a_ready = 1'b0;
        a_word = 48'h0000_0000_1111; a_word_valid = 1'b1;
        @(negedge clk);
        a_word = 48'h0000_0000_2222;
        @(negedge clk);
        a_word_valid = 1'b0;
        #1;
        check("rst_pre_a_valid", 64'(a_valid), 64'(1));
        rst_in = 1'b1; a_ready = 1'b1;
        #1;
        check("rst_in_a_valid", 64'(a_valid), 64'(0));
        check("rst_in_oe", 64'(io_bus_oe), 64'(0));
        check("rst_in_bus", 64'(io_bus_out), 64'(0));
        check("rst_in_a_word_ready", 64'(a_word_ready), 64'(0));
        check("rst_in_idle", 64'(idle), 64'(0));
        check("rst_in_a_sent", 64'(a_sent), 64'(0));
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        check("rst_post_a_valid", 64'(a_valid), 64'(0));
        check("rst_post_a_sent", 64'(a_sent), 64'(0));
        check("rst_post_b_sent", 64'(b_sent), 64'(0));
        check("rst_post_idle", 64'(idle), 64'(1));
        check("rst_post_a_word_ready", 64'(a_word_ready), 64'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_quiet%0d_oe", k), 64'(io_bus_oe), 64'(0));
            check($sformatf("rst_quiet%0d_a_sent", k), 64'(a_sent), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
